// File: rtl/cpu_fetch_unit_if.sv
// Instruction memory strobe/ack bus between the fetch unit (master) and imem (slave).
interface cpu_fetch_unit_if;
  logic        stb;
  logic [31:0] adr;
  logic        ack;
  logic [31:0] dat;

  modport master (output stb, output adr, input ack, input dat);
  modport slave  (input stb, input adr, output ack, output dat);
endinterface

// File: rtl/cpu_fetch_unit.sv
// Moxie instruction fetch: word fetches from imem into a halfword ring buffer, presenting
// opcode + 32-bit operand to decode with 2/6-byte consume and branch redirect/flush.
module cpu_fetch_unit #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_1000,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  cpu_fetch_unit_if.master       imem,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  output logic                   valid_o,
  output logic [15:0]            opcode_o,
  output logic [31:0]            operand_o,
  output logic [31:0]            pc_o,
  input  logic                   consume_i,
  input  logic                   long_i
);
  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StBus, StDrop} state_e;

  state_e            state_q, state_d;
  logic              stb_q, stb_d;
  logic [31:0]       adr_q, adr_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       pc_q, pc_d;
  logic              skip_hi_q, skip_hi_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]     count_q, count_d;
  logic [15:0]       buf_q [DEPTH];
  logic [15:0]       buf_d [DEPTH];

  logic [PtrW:0]     free;
  logic [1:0]        n_push;
  logic [1:0]        n_pop;
  logic [PtrW-1:0]   rd_ptr_p1, rd_ptr_p2, wr_ptr_p1;

  assign rd_ptr_p1 = rd_ptr_q + PtrW'(1);
  assign rd_ptr_p2 = rd_ptr_q + PtrW'(2);
  assign wr_ptr_p1 = wr_ptr_q + PtrW'(1);

  assign imem.stb  = stb_q;
  assign imem.adr  = adr_q;
  assign valid_o   = count_q >= (PtrW + 1)'(3);
  assign opcode_o  = buf_q[rd_ptr_q];
  assign operand_o = {buf_q[rd_ptr_p1], buf_q[rd_ptr_p2]};
  assign pc_o      = pc_q;

  always_comb begin
    state_d    = state_q;
    stb_d      = stb_q;
    adr_d      = adr_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    skip_hi_d  = skip_hi_q;
    buf_d      = buf_q;
    n_push     = 2'd0;
    n_pop      = 2'd0;
    free       = (PtrW + 1)'(DEPTH) - count_q;

    case (state_q)
      StIdle: begin
        // Two free slots guarantee a full word always fits when it arrives.
        if (free >= (PtrW + 1)'(2) && !redirect_i) begin
          stb_d   = 1'b1;
          adr_d   = {fetch_pc_q[31:2], 2'b00};
          state_d = StBus;
        end
      end
      StBus: begin
        if (imem.ack) begin
          stb_d      = 1'b0;
          state_d    = StIdle;
          fetch_pc_d = adr_q + 32'd4;
          if (skip_hi_q) begin
            buf_d[wr_ptr_q] = imem.dat[15:0];
            n_push          = 2'd1;
            skip_hi_d       = 1'b0;
          end else begin
            buf_d[wr_ptr_q]  = imem.dat[31:16];
            buf_d[wr_ptr_p1] = imem.dat[15:0];
            n_push           = 2'd2;
          end
        end
      end
      StDrop: begin
        if (imem.ack) begin
          stb_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (valid_o && consume_i) begin
      n_pop = long_i ? 2'd3 : 2'd1;
    end

    rd_ptr_d = rd_ptr_q + PtrW'(n_pop);
    wr_ptr_d = wr_ptr_q + PtrW'(n_push);
    count_d  = count_q + (PtrW + 1)'(n_push) - (PtrW + 1)'(n_pop);
    pc_d     = pc_q + {29'd0, n_pop, 1'b0};

    // Redirect overrides any push, pop or fetch advance computed above.
    if (redirect_i) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      pc_d       = {redirect_pc_i[31:1], 1'b0};
      fetch_pc_d = {redirect_pc_i[31:1], 1'b0};
      skip_hi_d  = redirect_pc_i[1];
      if (state_q == StBus) begin
        if (imem.ack) begin
          stb_d   = 1'b0;
          state_d = StIdle;
        end else begin
          state_d = StDrop;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      stb_q      <= 1'b0;
      adr_q      <= BOOT_ADDRESS;
      fetch_pc_q <= BOOT_ADDRESS;
      pc_q       <= BOOT_ADDRESS;
      skip_hi_q  <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      stb_q      <= stb_d;
      adr_q      <= adr_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      skip_hi_q  <= skip_hi_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Buffer contents need no reset: count_q gates everything that reads them.
  always_ff @(posedge clk_i) begin
    buf_q <= buf_d;
  end

endmodule
